// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream
//   Routes one valid/ready input stream to one of N output channels picked per
//   beat by in_sel, or to every channel when in_bcast is set. Each channel has
//   a one-entry registered holding stage, so channels back-pressure
//   independently and outputs come straight from flops.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready is combinational)
//   in_data           payload, WIDTH bits
//   in_sel            destination channel index, SEL_W bits
//   in_bcast          send beat to all channels, in_sel ignored
//   out_valid[N]      per-channel beat present
//   out_ready[N]      per-channel consumer accept
//   out_data          channel i at [i*WIDTH +: WIDTH]
//   sel_err           one-cycle pulse per dropped out-of-range beat
//   drop_count        saturating count of dropped beats

// One channel holding stage: full flag plus data register.
module demux_1ton_chan #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             free
);
   // A full stage that drains this cycle can take a new beat on the same edge.
   assign free = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

module demux_1ton_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SEL_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_bcast,
   output logic [N-1:0]         out_valid,
   input  logic [N-1:0]         out_ready,
   output logic [N*WIDTH-1:0]   out_data,
   output logic                 sel_err,
   output logic [7:0]           drop_count
);
   localparam int NSEL = 1 << SEL_W;

   logic [N-1:0]            free;
   logic [N-1:0]            load;
   logic [N-1:0][WIDTH-1:0] ch_data;
   logic [NSEL-1:0]         free_ext;
   logic                    sel_ok;
   logic                    xfer;
   logic                    drop;

   // Unused select codes read as always-free so out-of-range beats are
   // accepted (and dropped) without any out-of-range indexing.
   always_comb begin
      free_ext          = '1;
      free_ext[N-1:0]   = free;
   end

   assign sel_ok   = 32'(in_sel) < N;
   assign in_ready = in_bcast ? &free : free_ext[in_sel];
   assign xfer     = in_valid && in_ready;
   assign drop     = xfer && !in_bcast && !sel_ok;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_chan
         assign load[i] = xfer && (in_bcast || in_sel == SEL_W'(i));

         demux_1ton_chan #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .in_data   (in_data),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (ch_data[i]),
            .free      (free[i])
         );
      end
   endgenerate

   // Packed array element i lands at bits [i*WIDTH +: WIDTH].
   assign out_data = ch_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err    <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         sel_err <= drop;
         if (drop && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
      end
   end
endmodule
